// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch unit (master)
// and a variable-latency instruction memory (slave).
interface if_fetch_unit_if #(
    parameter int pc_size   = 18,
    parameter int data_size = 32
);
    logic                 req;
    logic [pc_size-1:0]   addr;
    logic                 ready;
    logic [data_size-1:0] rdata;

    modport master (
        output req,
        output addr,
        input  ready,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output ready,
        output rdata
    );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ready memory bus,
// inserts bubbles while memory is busy and buffers an instruction across stalls.
module if_fetch_unit #(
    parameter int                 pc_size   = 18,
    parameter int                 data_size = 32,
    parameter logic [pc_size-1:0] reset_pc  = {pc_size{1'b0}}
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  PCWrite,
    input  logic                  branch_taken,
    input  logic [pc_size-1:0]    branch_target,
    if_fetch_unit_if.master       imem,
    output logic [pc_size-1:0]    IF_PC,
    output logic [data_size-1:0]  IF_ir,
    output logic                  IF_Flush
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HELD  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [pc_size-1:0]   PC_STEP   = pc_size'(3'd4);
    localparam logic [pc_size-1:0]   ALIGN_MSK = ~(pc_size'(2'b11));
    localparam logic [data_size-1:0] NOP_IR    = {data_size{1'b0}};

    state_t               state_r;
    logic [pc_size-1:0]   pc_r;
    logic [pc_size-1:0]   drain_addr_r;
    logic [pc_size-1:0]   if_pc_r;
    logic [data_size-1:0] buf_r;
    logic [data_size-1:0] if_ir_r;
    logic [pc_size-1:0]   pc_next_s;
    logic [pc_size-1:0]   target_s;

    function automatic logic [pc_size-1:0] pc_inc(input logic [pc_size-1:0] pc);
        return pc + PC_STEP;
    endfunction

    function automatic logic [pc_size-1:0] word_align(input logic [pc_size-1:0] a);
        return a & ALIGN_MSK;
    endfunction

    assign pc_next_s = pc_inc(pc_r);
    assign target_s  = word_align(branch_target);

    // Fetch FSM: PC, drain address, stall buffer and the IF/ID-facing registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= FETCH;
            pc_r         <= reset_pc;
            drain_addr_r <= reset_pc;
            buf_r        <= NOP_IR;
            if_ir_r      <= NOP_IR;
            if_pc_r      <= {pc_size{1'b0}};
        end else begin
            case (state_r)
                FETCH: begin
                    if (branch_taken) begin
                        pc_r    <= target_s;
                        if_ir_r <= NOP_IR;
                        // A request still in flight must be drained before the new PC is issued.
                        if (imem.ready) begin
                            state_r <= FETCH;
                        end else begin
                            drain_addr_r <= pc_r;
                            state_r      <= DRAIN;
                        end
                    end else if (!PCWrite) begin
                        if (imem.ready) begin
                            buf_r   <= imem.rdata;
                            state_r <= HELD;
                        end else begin
                            state_r <= FETCH;
                        end
                    end else if (imem.ready) begin
                        if_ir_r <= imem.rdata;
                        if_pc_r <= pc_next_s;
                        pc_r    <= pc_next_s;
                        state_r <= FETCH;
                    end else begin
                        if_ir_r <= NOP_IR;
                        state_r <= FETCH;
                    end
                end
                HELD: begin
                    if (branch_taken) begin
                        pc_r    <= target_s;
                        if_ir_r <= NOP_IR;
                        state_r <= FETCH;
                    end else if (PCWrite) begin
                        if_ir_r <= buf_r;
                        if_pc_r <= pc_next_s;
                        pc_r    <= pc_next_s;
                        state_r <= FETCH;
                    end else begin
                        state_r <= HELD;
                    end
                end
                DRAIN: begin
                    if_ir_r <= NOP_IR;
                    if (branch_taken) begin
                        pc_r <= target_s;
                    end else begin
                        pc_r <= pc_r;
                    end
                    // The stale response completes the old request; drop its data.
                    if (imem.ready) begin
                        state_r <= FETCH;
                    end else begin
                        state_r <= DRAIN;
                    end
                end
                default: begin
                    if_ir_r <= NOP_IR;
                    state_r <= FETCH;
                end
            endcase
        end
    end

    assign imem.req  = (state_r != HELD);
    assign imem.addr = (state_r == DRAIN) ? drain_addr_r : pc_r;
    assign IF_PC     = if_pc_r;
    assign IF_ir     = if_ir_r;
    assign IF_Flush  = branch_taken;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Cycle-by-cycle vector bench for if_fetch_unit with a scoreboard queue for
// the registered IF/ID outputs.
module tb_if_fetch_unit;
    localparam int PW = 18;
    localparam int DW = 32;
    localparam int NV = 21;

    logic          clk = 1'b0;
    logic          rst;
    logic          pcwrite;
    logic          br;
    logic [PW-1:0] tgt;
    logic [PW-1:0] if_pc;
    logic [DW-1:0] if_ir;
    logic          flush;

    if_fetch_unit_if #(.pc_size(PW), .data_size(DW)) imem ();

    if_fetch_unit #(.pc_size(PW), .data_size(DW), .reset_pc(18'h0)) dut (
        .clk           (clk),
        .rst           (rst),
        .PCWrite       (pcwrite),
        .branch_taken  (br),
        .branch_target (tgt),
        .imem          (imem),
        .IF_PC         (if_pc),
        .IF_ir         (if_ir),
        .IF_Flush      (flush)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          rst;
        logic          pcw;
        logic          br;
        logic [PW-1:0] tgt;
        logic          rdy;
        logic          req;   // expected imem_req before the edge
        logic [PW-1:0] addr;  // expected imem_addr before the edge (if req)
        logic [DW-1:0] ir;    // expected IF_ir after the edge
        logic [PW-1:0] pc;    // expected IF_PC after the edge
    } vec_t;

    typedef struct {
        logic [DW-1:0] ir;
        logic [PW-1:0] pc;
    } exp_t;

    vec_t tbl [NV];
    exp_t sb_q [$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic logic [DW-1:0] mem_data(input logic [PW-1:0] a);
        return 32'hA500_0000 | {14'd0, a};
    endfunction

    function automatic vec_t mk(input logic r, input logic w, input logic b,
                                input logic [PW-1:0] t, input logic y, input logic q,
                                input logic [PW-1:0] a, input logic [DW-1:0] ir,
                                input logic [PW-1:0] pc);
        vec_t v;
        v.rst = r; v.pcw = w; v.br = b; v.tgt = t; v.rdy = y;
        v.req = q; v.addr = a; v.ir = ir; v.pc = pc;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    task automatic step(input vec_t v, input string tag);
        exp_t e;
        exp_t got;
        @(negedge clk);
        rst        = v.rst;
        pcwrite    = v.pcw;
        br         = v.br;
        tgt        = v.tgt;
        imem.ready = v.rdy;
        #1;
        imem.rdata = mem_data(imem.addr);
        if (!v.rst) begin
            check({tag, " flush"}, {31'd0, flush}, {31'd0, v.br});
            check({tag, " req"}, {31'd0, imem.req}, {31'd0, v.req});
            if (v.req) begin
                check({tag, " addr"}, {14'd0, imem.addr}, {14'd0, v.addr});
            end
        end
        e.ir = v.ir;
        e.pc = v.pc;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        got = sb_q.pop_front();
        check({tag, " IF_ir"}, if_ir, got.ir);
        check({tag, " IF_PC"}, {14'd0, if_pc}, {14'd0, got.pc});
    endtask

    initial begin
        rst = 1'b1; pcwrite = 1'b1; br = 1'b0; tgt = 18'h0;
        imem.ready = 1'b0; imem.rdata = 32'h0;

        //         rst   pcw   br    tgt      rdy   req   addr     ir                     pc
        tbl[0]  = mk(1'b1, 1'b1, 1'b0, 18'h0,   1'b0, 1'b0, 18'h0,   32'h0,                 18'h0);
        tbl[1]  = mk(1'b0, 1'b1, 1'b0, 18'h0,   1'b1, 1'b1, 18'h0,   mem_data(18'h0),       18'h4);
        tbl[2]  = mk(1'b0, 1'b1, 1'b0, 18'h0,   1'b1, 1'b1, 18'h4,   mem_data(18'h4),       18'h8);
        tbl[3]  = mk(1'b0, 1'b1, 1'b0, 18'h0,   1'b1, 1'b1, 18'h8,   mem_data(18'h8),       18'hC);
        tbl[4]  = mk(1'b0, 1'b1, 1'b0, 18'h0,   1'b1, 1'b1, 18'hC,   mem_data(18'hC),       18'h10);
        tbl[5]  = mk(1'b0, 1'b1, 1'b0, 18'h0,   1'b0, 1'b1, 18'h10,  32'h0,                 18'h10);
        tbl[6]  = mk(1'b0, 1'b1, 1'b0, 18'h0,   1'b1, 1'b1, 18'h10,  mem_data(18'h10),      18'h14);
        tbl[7]  = mk(1'b0, 1'b1, 1'b0, 18'h0,   1'b0, 1'b1, 18'h14,  32'h0,                 18'h14);
        tbl[8]  = mk(1'b0, 1'b1, 1'b0, 18'h0,   1'b1, 1'b1, 18'h14,  mem_data(18'h14),      18'h18);
        tbl[9]  = mk(1'b1, 1'b1, 1'b0, 18'h0,   1'b0, 1'b0, 18'h0,   32'h0,                 18'h0);
        tbl[10] = mk(1'b0, 1'b1, 1'b0, 18'h0,   1'b1, 1'b1, 18'h0,   mem_data(18'h0),       18'h4);
        tbl[11] = mk(1'b0, 1'b1, 1'b0, 18'h0,   1'b1, 1'b1, 18'h4,   mem_data(18'h4),       18'h8);
        tbl[12] = mk(1'b0, 1'b0, 1'b0, 18'h0,   1'b1, 1'b1, 18'h8,   mem_data(18'h4),       18'h8);
        tbl[13] = mk(1'b0, 1'b0, 1'b0, 18'h0,   1'b1, 1'b0, 18'h0,   mem_data(18'h4),       18'h8);
        tbl[14] = mk(1'b0, 1'b0, 1'b0, 18'h0,   1'b0, 1'b0, 18'h0,   mem_data(18'h4),       18'h8);
        tbl[15] = mk(1'b0, 1'b1, 1'b0, 18'h0,   1'b0, 1'b0, 18'h0,   mem_data(18'h8),       18'hC);
        tbl[16] = mk(1'b0, 1'b1, 1'b0, 18'h0,   1'b1, 1'b1, 18'hC,   mem_data(18'hC),       18'h10);
        tbl[17] = mk(1'b0, 1'b1, 1'b1, 18'h100, 1'b0, 1'b1, 18'h10,  32'h0,                 18'h10);
        tbl[18] = mk(1'b0, 1'b1, 1'b0, 18'h0,   1'b0, 1'b1, 18'h10,  32'h0,                 18'h10);
        tbl[19] = mk(1'b0, 1'b1, 1'b0, 18'h0,   1'b1, 1'b1, 18'h10,  32'h0,                 18'h10);
        tbl[20] = mk(1'b0, 1'b1, 1'b0, 18'h0,   1'b1, 1'b1, 18'h100, mem_data(18'h100),     18'h104);

        for (int i = 0; i < NV; i++) begin
            step(tbl[i], $sformatf("v%0d", i));
        end

        // Redirect with same-cycle ready onto an unaligned top-of-space target, then PC wrap.
        step(mk(1'b0, 1'b1, 1'b1, 18'h3FFFE, 1'b1, 1'b1, 18'h104,   32'h0,              18'h104), "wrap0");
        step(mk(1'b0, 1'b1, 1'b0, 18'h0,     1'b1, 1'b1, 18'h3FFFC, mem_data(18'h3FFFC), 18'h0),  "wrap1");
        step(mk(1'b0, 1'b1, 1'b0, 18'h0,     1'b1, 1'b1, 18'h0,     mem_data(18'h0),     18'h4),  "wrap2");

        // Reset while draining a redirected request.
        step(mk(1'b0, 1'b1, 1'b1, 18'h200, 1'b0, 1'b1, 18'h4, 32'h0,           18'h4), "rstd0");
        step(mk(1'b1, 1'b1, 1'b0, 18'h0,   1'b0, 1'b0, 18'h0, 32'h0,           18'h0), "rstd1");
        step(mk(1'b0, 1'b1, 1'b0, 18'h0,   1'b0, 1'b1, 18'h0, 32'h0,           18'h0), "rstd2");
        step(mk(1'b0, 1'b1, 1'b0, 18'h0,   1'b1, 1'b1, 18'h0, mem_data(18'h0), 18'h4), "rstd3");

        // Redirect out of HELD drops the buffered instruction.
        step(mk(1'b0, 1'b0, 1'b0, 18'h0,  1'b1, 1'b1, 18'h4,  mem_data(18'h0),  18'h4),  "held0");
        step(mk(1'b0, 1'b0, 1'b1, 18'h40, 1'b0, 1'b0, 18'h0,  32'h0,            18'h4),  "held1");
        step(mk(1'b0, 1'b1, 1'b0, 18'h0,  1'b1, 1'b1, 18'h40, mem_data(18'h40), 18'h44), "held2");

        // Second redirect during DRAIN retargets without leaving DRAIN.
        step(mk(1'b0, 1'b1, 1'b1, 18'h80, 1'b0, 1'b1, 18'h44, 32'h0,            18'h44), "dr0");
        step(mk(1'b0, 1'b1, 1'b1, 18'hC0, 1'b0, 1'b1, 18'h44, 32'h0,            18'h44), "dr1");
        step(mk(1'b0, 1'b1, 1'b0, 18'h0,  1'b1, 1'b1, 18'h44, 32'h0,            18'h44), "dr2");
        step(mk(1'b0, 1'b1, 1'b0, 18'h0,  1'b1, 1'b1, 18'hC0, mem_data(18'hC0), 18'hC4), "dr3");

        // Stall with no response keeps the request up and outputs frozen.
        step(mk(1'b0, 1'b0, 1'b0, 18'h0, 1'b0, 1'b1, 18'hC4, mem_data(18'hC0), 18'hC4), "st0");
        step(mk(1'b0, 1'b1, 1'b0, 18'h0, 1'b1, 1'b1, 18'hC4, mem_data(18'hC4), 18'hC8), "st1");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
